// File: rtl/xr_host_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xr_host_port: host-strobe to XR bus initiator with a write queue and an     |
// | auto-incrementing read prefetch. Optional macro: XR_HOST_ERRFLAGS_EN.       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module xr_host_port #(
  parameter int WQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        host_rd_addr_wr_i,
  input  logic        host_wr_addr_wr_i,
  input  logic        host_data_wr_i,
  input  logic        host_data_rd_i,
  input  logic [15:0] host_addr_i,
  input  logic [15:0] host_data_i,
  input  logic [15:0] host_rd_incr_i,
  input  logic [15:0] host_wr_incr_i,
  output logic [15:0] host_rd_data_o,
  output logic        host_rd_valid_o,
  output logic        host_busy_o,
  input  logic        host_err_clr_i,
  output logic        host_wr_ovf_o,
  output logic        host_rd_unf_o,
  output logic        xr_sel_o,
  output logic        xr_wr_o,
  output logic [15:0] xr_addr_o,
  output logic [15:0] xr_data_o,
  input  logic        xr_ack_i,
  input  logic [15:0] xr_data_i
);

  localparam int c_aw = $clog2(WQ_DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_full = c_cw'(WQ_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [15:0]       r_q_addr [WQ_DEPTH];
  logic [15:0]       r_q_data [WQ_DEPTH];
  logic [c_aw-1:0]   r_head;
  logic [c_aw-1:0]   r_tail;
  logic [c_cw-1:0]   r_count;

  logic [15:0]       r_wr_addr;
  logic [15:0]       r_rd_addr;
  logic [15:0]       r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_pending;
  logic              r_discard;

  logic              r_sel;
  logic              r_wr;
  logic [15:0]       r_xaddr;
  logic [15:0]       r_xdata;

  logic              w_push;
  logic              w_pop;
  logic              w_rd_ack;
  logic              w_rd_take;
  logic              w_slot;
  logic              w_q_avail;
  logic [c_aw-1:0]   w_issue_idx;
  logic              w_issue_rd;
  logic              w_sel_nxt;
  logic              w_wr_nxt;
  logic [15:0]       w_xaddr_nxt;
  logic [15:0]       w_xdata_nxt;

  // Fullness uses the registered count, so a same-cycle pop never rescues a push.
  assign w_push    = host_data_wr_i && (r_count != c_full);
  assign w_pop     = xr_ack_i && (r_state == ST_WRITE);
  assign w_rd_ack  = xr_ack_i && (r_state == ST_READ);
  assign w_rd_take = host_data_rd_i && r_rd_valid;
  assign w_slot    = (r_state == ST_IDLE) || xr_ack_i;

  // On a write ack the head is leaving, so the next candidate is the entry behind it.
  assign w_q_avail   = (r_state == ST_WRITE) ? (r_count > c_cw'(1)) : (r_count != '0);
  assign w_issue_idx = (r_state == ST_WRITE) ? r_head + 1'b1 : r_head;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_wr_nxt    = r_wr;
    w_xaddr_nxt = r_xaddr;
    w_xdata_nxt = r_xdata;
    w_issue_rd  = 1'b0;
    if (w_slot) begin
      if (w_q_avail) begin
        w_state_nxt = ST_WRITE;
        w_sel_nxt   = 1'b1;
        w_wr_nxt    = 1'b1;
        w_xaddr_nxt = r_q_addr[w_issue_idx];
        w_xdata_nxt = r_q_data[w_issue_idx];
      end else if (r_rd_pending) begin
        w_state_nxt = ST_READ;
        w_sel_nxt   = 1'b1;
        w_wr_nxt    = 1'b0;
        w_xaddr_nxt = r_rd_addr;
        w_issue_rd  = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = 1'b0;
        w_wr_nxt    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_wr    <= 1'b0;
      r_xaddr <= '0;
      r_xdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_wr    <= w_wr_nxt;
      r_xaddr <= w_xaddr_nxt;
      r_xdata <= w_xdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_tail] <= r_wr_addr;
      r_q_data[r_tail] <= host_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // An address load beats the increment; the push in that cycle used the old address.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_wr_addr <= '0;
    end else if (host_wr_addr_wr_i) begin
      r_wr_addr <= host_addr_i;
    end else if (w_push) begin
      r_wr_addr <= r_wr_addr + host_wr_incr_i;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_rd_addr    <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_pending <= 1'b0;
    end else if (host_rd_addr_wr_i) begin
      r_rd_addr    <= host_addr_i;
      r_rd_valid   <= 1'b0;
      r_rd_pending <= 1'b1;
    end else if (w_rd_take) begin
      r_rd_addr    <= r_rd_addr + host_rd_incr_i;
      r_rd_valid   <= 1'b0;
      r_rd_pending <= 1'b1;
    end else begin
      if (w_issue_rd) r_rd_pending <= 1'b0;
      if (w_rd_ack && !r_discard) begin
        r_rd_data  <= xr_data_i;
        r_rd_valid <= 1'b1;
      end
    end
  end

  // A read issued or outstanding while the address is reloaded returns stale data.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_discard <= 1'b0;
    end else if (host_rd_addr_wr_i && (((r_state == ST_READ) && !xr_ack_i) || w_issue_rd)) begin
      r_discard <= 1'b1;
    end else if (w_rd_ack) begin
      r_discard <= 1'b0;
    end
  end

`ifdef XR_HOST_ERRFLAGS_EN
  logic r_wr_ovf;
  logic r_rd_unf;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ovf <= 1'b0;
      r_rd_unf <= 1'b0;
    end else begin
      if (host_data_wr_i && !w_push) r_wr_ovf <= 1'b1;
      else if (host_err_clr_i)       r_wr_ovf <= 1'b0;
      if (host_data_rd_i && !r_rd_valid) r_rd_unf <= 1'b1;
      else if (host_err_clr_i)           r_rd_unf <= 1'b0;
    end
  end

  assign host_wr_ovf_o = r_wr_ovf;
  assign host_rd_unf_o = r_rd_unf;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = host_err_clr_i;
  assign host_wr_ovf_o    = 1'b0;
  assign host_rd_unf_o    = 1'b0;
`endif

  assign host_rd_data_o  = r_rd_data;
  assign host_rd_valid_o = r_rd_valid;
  assign host_busy_o     = (r_count != '0) || r_rd_pending || (r_state != ST_IDLE);

  assign xr_sel_o  = r_sel;
  assign xr_wr_o   = r_wr;
  assign xr_addr_o = r_xaddr;
  assign xr_data_o = r_xdata;

endmodule
`default_nettype wire

// File: tb/tb_xr_host_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_xr_host_port: directed bench for xr_host_port with a registered-ack      |
// | XR responder. Rev 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_xr_host_port;

`ifdef XR_HOST_ERRFLAGS_EN
  localparam logic FLAG_ON = 1'b1;
`else
  localparam logic FLAG_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        host_rd_addr_wr_i = 1'b0;
  logic        host_wr_addr_wr_i = 1'b0;
  logic        host_data_wr_i = 1'b0;
  logic        host_data_rd_i = 1'b0;
  logic [15:0] host_addr_i = '0;
  logic [15:0] host_data_i = '0;
  logic [15:0] host_rd_incr_i = '0;
  logic [15:0] host_wr_incr_i = '0;
  logic [15:0] host_rd_data_o;
  logic        host_rd_valid_o;
  logic        host_busy_o;
  logic        host_err_clr_i = 1'b0;
  logic        host_wr_ovf_o;
  logic        host_rd_unf_o;
  logic        xr_sel_o;
  logic        xr_wr_o;
  logic [15:0] xr_addr_o;
  logic [15:0] xr_data_o;
  logic        xr_ack_i;
  logic [15:0] xr_data_i;

  logic        ack_en = 1'b1;
  logic [15:0] mem [65536];
  bit          mem_wr [65536];
  logic [32:0] log_q [$];
  int          checks = 0;
  int          passes = 0;

  xr_host_port #(.WQ_DEPTH(4)) dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .host_rd_addr_wr_i (host_rd_addr_wr_i),
    .host_wr_addr_wr_i (host_wr_addr_wr_i),
    .host_data_wr_i    (host_data_wr_i),
    .host_data_rd_i    (host_data_rd_i),
    .host_addr_i       (host_addr_i),
    .host_data_i       (host_data_i),
    .host_rd_incr_i    (host_rd_incr_i),
    .host_wr_incr_i    (host_wr_incr_i),
    .host_rd_data_o    (host_rd_data_o),
    .host_rd_valid_o   (host_rd_valid_o),
    .host_busy_o       (host_busy_o),
    .host_err_clr_i    (host_err_clr_i),
    .host_wr_ovf_o     (host_wr_ovf_o),
    .host_rd_unf_o     (host_rd_unf_o),
    .xr_sel_o          (xr_sel_o),
    .xr_wr_o           (xr_wr_o),
    .xr_addr_o         (xr_addr_o),
    .xr_data_o         (xr_data_o),
    .xr_ack_i          (xr_ack_i),
    .xr_data_i         (xr_data_i)
  );

  always #5 clk = ~clk;

  // Registered responder: one ack per access, reads return written data or addr^0x5555.
  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      xr_ack_i  <= 1'b0;
      xr_data_i <= '0;
    end else begin
      xr_ack_i <= xr_sel_o && !xr_ack_i && ack_en;
      if (xr_sel_o && !xr_ack_i && ack_en) begin
        if (xr_wr_o) begin
          mem[xr_addr_o]    <= xr_data_o;
          mem_wr[xr_addr_o] <= 1'b1;
          xr_data_i         <= '0;
        end else if (mem_wr[xr_addr_o]) begin
          xr_data_i <= mem[xr_addr_o];
        end else begin
          xr_data_i <= xr_addr_o ^ 16'h5555;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (xr_sel_o && xr_ack_i) log_q.push_back({xr_wr_o, xr_addr_o, xr_data_o});
  end

  function automatic logic [32:0] log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 33'h1_FFFF_FFFF;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_wr(input logic [15:0] a);
    host_wr_addr_wr_i = 1'b1; host_addr_i = a; tick(); host_wr_addr_wr_i = 1'b0;
  endtask

  task automatic load_rd(input logic [15:0] a);
    host_rd_addr_wr_i = 1'b1; host_addr_i = a; tick(); host_rd_addr_wr_i = 1'b0;
  endtask

  task automatic pulse_rd();
    host_data_rd_i = 1'b1; tick(); host_data_rd_i = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !host_rd_valid_o; i++) tick();
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && host_busy_o; i++) tick();
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if ({xr_sel_o, xr_wr_o, host_rd_valid_o, host_busy_o, host_wr_ovf_o, host_rd_unf_o} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000",
               {xr_sel_o, xr_wr_o, host_rd_valid_o, host_busy_o, host_wr_ovf_o, host_rd_unf_o});
    else passes++;
    checks++;
    if ({xr_addr_o, xr_data_o, host_rd_data_o} !== 48'h0)
      $display("FAIL reset_data: got %h want 0", {xr_addr_o, xr_data_o, host_rd_data_o});
    else passes++;
    reset_i = 1'b0;
    tick(2);
  endtask

  task automatic test_write_burst();
    int gaps = 0;
    bit seen = 1'b0;
    logic [32:0] exp;
    log_q.delete();
    host_wr_incr_i = 16'd1;
    load_wr(16'h8000);
    host_data_wr_i = 1'b1;
    host_data_i = 16'h1111; tick();
    host_data_i = 16'h2222; tick();
    host_data_i = 16'h3333; tick();
    host_data_wr_i = 1'b0;
    for (int i = 0; i < 40 && log_q.size() < 3; i++) begin
      if (xr_sel_o) seen = 1'b1;
      else if (seen) gaps++;
      tick();
    end
    checks++;
    if (log_q.size() != 3) $display("FAIL burst_count: got %0d want 3", log_q.size());
    else passes++;
    for (int i = 0; i < 3; i++) begin
      exp = {1'b1, 16'h8000 + 16'(i), 16'(16'h1111 * (i + 1))};
      checks++;
      if (log_at(i) !== exp) $display("FAIL burst_wr%0d: got %h want %h", i, log_at(i), exp);
      else passes++;
    end
    checks++;
    if (gaps != 0) $display("FAIL burst_sel_gap: got %0d idle cycles want 0", gaps);
    else passes++;
    checks++;
    if (host_busy_o !== 1'b0) $display("FAIL burst_busy: got %b want 0", host_busy_o);
    else passes++;
  endtask

  task automatic test_read_prefetch();
    log_q.delete();
    host_rd_incr_i = 16'd2;
    load_rd(16'hA010);
    wait_valid(20);
    checks++;
    if ({host_rd_valid_o, host_rd_data_o} !== {1'b1, 16'hF545})
      $display("FAIL rd_first: got %b/%h want 1/f545", host_rd_valid_o, host_rd_data_o);
    else passes++;
    checks++;
    if (log_at(0)[32:16] !== {1'b0, 16'hA010})
      $display("FAIL rd_first_addr: got %h want 0a010", log_at(0)[32:16]);
    else passes++;
    pulse_rd();
    checks++;
    if (host_rd_valid_o !== 1'b0) $display("FAIL rd_valid_drop: got %b want 0", host_rd_valid_o);
    else passes++;
    wait_valid(20);
    checks++;
    if ({host_rd_valid_o, host_rd_data_o} !== {1'b1, 16'hF547})
      $display("FAIL rd_second: got %b/%h want 1/f547", host_rd_valid_o, host_rd_data_o);
    else passes++;
    checks++;
    if (log_at(1)[32:16] !== {1'b0, 16'hA012})
      $display("FAIL rd_second_addr: got %h want 0a012", log_at(1)[32:16]);
    else passes++;
    // consume, then read again while empty with a clear in the same cycle
    pulse_rd();
    host_data_rd_i = 1'b1; host_err_clr_i = 1'b1; tick();
    host_data_rd_i = 1'b0; host_err_clr_i = 1'b0;
    checks++;
    if (host_rd_unf_o !== FLAG_ON) $display("FAIL rd_unf_set: got %b want %b", host_rd_unf_o, FLAG_ON);
    else passes++;
    wait_valid(20);
    checks++;
    if ({host_rd_valid_o, host_rd_data_o} !== {1'b1, 16'hF541})
      $display("FAIL rd_third: got %b/%h want 1/f541", host_rd_valid_o, host_rd_data_o);
    else passes++;
    tick();
    checks++;
    if ({host_busy_o, 6'(log_q.size())} !== {1'b0, 6'd3})
      $display("FAIL rd_no_extra: got busy %b reads %0d want busy 0 reads 3", host_busy_o, log_q.size());
    else passes++;
    host_err_clr_i = 1'b1; tick(); host_err_clr_i = 1'b0;
    checks++;
    if (host_rd_unf_o !== 1'b0) $display("FAIL rd_unf_clr: got %b want 0", host_rd_unf_o);
    else passes++;
  endtask

  task automatic test_overflow();
    logic [32:0] exp;
    log_q.delete();
    ack_en = 1'b0;
    load_wr(16'h1000);
    host_data_wr_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_data_i = 16'h5000 + 16'(i);
      tick();
    end
    host_data_wr_i = 1'b0;
    tick(2);
    checks++;
    if (host_wr_ovf_o !== FLAG_ON) $display("FAIL ovf_set: got %b want %b", host_wr_ovf_o, FLAG_ON);
    else passes++;
    checks++;
    if ({xr_sel_o, xr_wr_o, xr_addr_o, 6'(log_q.size())} !== {1'b1, 1'b1, 16'h1000, 6'd0})
      $display("FAIL ovf_stalled: got sel %b wr %b addr %h acks %0d want 1 1 1000 0",
               xr_sel_o, xr_wr_o, xr_addr_o, log_q.size());
    else passes++;
    ack_en = 1'b1;
    wait_idle(60);
    checks++;
    if (log_q.size() != 4) $display("FAIL ovf_count: got %0d want 4", log_q.size());
    else passes++;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, 16'h1000 + 16'(i), 16'h5000 + 16'(i)};
      checks++;
      if (log_at(i) !== exp) $display("FAIL ovf_wr%0d: got %h want %h", i, log_at(i), exp);
      else passes++;
    end
    host_data_wr_i = 1'b1; host_data_i = 16'h6000; tick(); host_data_wr_i = 1'b0;
    wait_idle(20);
    checks++;
    if (log_at(4) !== {1'b1, 16'h1004, 16'h6000})
      $display("FAIL ovf_next_addr: got %h want 110046000", log_at(4));
    else passes++;
    checks++;
    if (host_wr_ovf_o !== FLAG_ON) $display("FAIL ovf_sticky: got %b want %b", host_wr_ovf_o, FLAG_ON);
    else passes++;
    host_err_clr_i = 1'b1; tick(); host_err_clr_i = 1'b0;
    checks++;
    if (host_wr_ovf_o !== 1'b0) $display("FAIL ovf_clr: got %b want 0", host_wr_ovf_o);
    else passes++;
  endtask

  task automatic test_order();
    log_q.delete();
    load_wr(16'h4005);
    host_data_wr_i = 1'b1; host_data_i = 16'hBEEF;
    host_rd_addr_wr_i = 1'b1; host_addr_i = 16'h4005;
    tick();
    host_data_wr_i = 1'b0; host_rd_addr_wr_i = 1'b0;
    wait_valid(30);
    checks++;
    if (log_at(0) !== {1'b1, 16'h4005, 16'hBEEF})
      $display("FAIL order_write_first: got %h want 14005beef", log_at(0));
    else passes++;
    checks++;
    if (log_at(1)[32:16] !== {1'b0, 16'h4005})
      $display("FAIL order_read_second: got %h want 04005", log_at(1)[32:16]);
    else passes++;
    checks++;
    if ({host_rd_valid_o, host_rd_data_o} !== {1'b1, 16'hBEEF})
      $display("FAIL order_data: got %b/%h want 1/beef", host_rd_valid_o, host_rd_data_o);
    else passes++;
    wait_idle(10);
  endtask

  task automatic test_wr_addr_collision();
    log_q.delete();
    host_data_wr_i = 1'b1; host_data_i = 16'h7777;
    host_wr_addr_wr_i = 1'b1; host_addr_i = 16'h3000;
    tick();
    host_wr_addr_wr_i = 1'b0; host_data_i = 16'h8888;
    tick();
    host_data_wr_i = 1'b0;
    wait_idle(30);
    checks++;
    if (log_at(0) !== {1'b1, 16'h4006, 16'h7777})
      $display("FAIL coll_old_addr: got %h want 140067777", log_at(0));
    else passes++;
    checks++;
    if (log_at(1) !== {1'b1, 16'h3000, 16'h8888})
      $display("FAIL coll_new_addr: got %h want 130008888", log_at(1));
    else passes++;
  endtask

  task automatic test_redirect();
    int bad = 0;
    log_q.delete();
    ack_en = 1'b0;
    load_rd(16'h0100);
    tick();
    for (int i = 0; i < 7; i++) begin
      if (!(xr_sel_o && !xr_wr_o && xr_addr_o == 16'h0100)) bad++;
      if (i == 3) begin
        host_rd_addr_wr_i = 1'b1; host_addr_i = 16'h0200;
      end
      tick();
      host_rd_addr_wr_i = 1'b0;
    end
    checks++;
    if (bad != 0) $display("FAIL redir_hold: got %0d unstable cycles want 0", bad);
    else passes++;
    ack_en = 1'b1;
    wait_valid(30);
    checks++;
    if ({host_rd_valid_o, host_rd_data_o} !== {1'b1, 16'h5755})
      $display("FAIL redir_data: got %b/%h want 1/5755", host_rd_valid_o, host_rd_data_o);
    else passes++;
    checks++;
    if ({log_at(0)[32:16], log_at(1)[32:16]} !== {1'b0, 16'h0100, 1'b0, 16'h0200})
      $display("FAIL redir_seq: got %h %h want 00100 00200", log_at(0)[32:16], log_at(1)[32:16]);
    else passes++;
    wait_idle(10);
  endtask

  task automatic test_reset_mid();
    log_q.delete();
    ack_en = 1'b0;
    host_data_wr_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_data_i = 16'hC000 + 16'(i);
      tick();
    end
    host_data_wr_i = 1'b0;
    checks++;
    if (xr_sel_o !== 1'b1) $display("FAIL rstmid_pre_sel: got %b want 1", xr_sel_o);
    else passes++;
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (xr_sel_o !== 1'b0) $display("FAIL rstmid_sel_async: got %b want 0", xr_sel_o);
    else passes++;
    checks++;
    if ({host_busy_o, host_rd_valid_o, host_wr_ovf_o, host_rd_unf_o} !== 4'b0)
      $display("FAIL rstmid_state: got %b want 0000",
               {host_busy_o, host_rd_valid_o, host_wr_ovf_o, host_rd_unf_o});
    else passes++;
    #2;
    reset_i = 1'b0;
    ack_en = 1'b1;
    tick(10);
    checks++;
    if ({xr_sel_o, 6'(log_q.size())} !== 7'b0)
      $display("FAIL rstmid_queue_empty: got sel %b acks %0d want 0 0", xr_sel_o, log_q.size());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_prefetch();
    test_overflow();
    test_order();
    test_wr_addr_collision();
    test_redirect();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
